instr_fetch_responder: RTL and testbench
========================================

Name: instr_fetch_responder

Overview:
Responder side of the PC interface. It accepts the instruction address driven by the PC each cycle and reads the instruction memory through a fixed-latency pipeline. Results go through an in-order output FIFO with a valid/ready handshake towards decode. It applies back-pressure to the PC, and on a jump redirect it kills every in-flight and buffered fetch.

Parameters:
ADDR_W, 32, address width of pc_addr / instr_pc
DATA_W, 32, instruction width
MEM_DEPTH, 1024, instruction memory depth in words (power of 2)
LATENCY, 2, cycles from address acceptance to instruction availability (legal 1..4)
INIT_FILE, "", hex file loaded with $readmemh at elaboration; no load if empty

Ports:
clk  in  1  single clock, rising-edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
pc_addr  in  ADDR_W  fetch byte address from PC (its out)
pc_valid  in  1  pc_addr is a fetch request this cycle
pc_hold  out  1  PC must not advance; request not accepted
flush  in  1  redirect (driven by j_signal); kills all outstanding fetches
instr  out  DATA_W  instruction at FIFO head
instr_pc  out  ADDR_W  address that produced instr
instr_valid  out  1  head entry valid
instr_ready  in  1  decode consumes head this cycle
misaligned  out  1  head entry had pc_addr[1:0] != 0
out_of_range  out  1  head entry had pc_addr>>2 >= MEM_DEPTH

Behaviour:
- Acceptance: request accepted at a rising edge iff pc_valid=1, pc_hold=0, flush=0. Throughput is 1 per cycle.
- Memory: word array indexed by pc_addr[log2(MEM_DEPTH)+1:2]. Synchronous read. Contents are not reset.
- Pipeline: LATENCY stages. Each stage carries {valid, pc, misaligned, out_of_range}.
- Latency: a request accepted at edge E0 is pushed into the FIFO at edge E0+LATENCY. instr_valid=1 right after that edge.
- FIFO: depth FDEPTH = LATENCY+2, in-order. Head drives instr/instr_pc/flags directly from registered storage. instr_valid = (count != 0).
- Pop: a pop occurs at an edge where instr_valid && instr_ready. Push and pop in the same edge are legal and leave count unchanged.
- Stability: while instr_valid && !instr_ready, all head outputs hold stable.
- Back-pressure: pc_hold = (fifo_count + inflight_count) >= FDEPTH. It is combinational from registers only, with no path from pc_valid or instr_ready. This credit rule guarantees the FIFO never overflows, so no push is ever dropped.
- Faults: for a misaligned or out-of-range address, the memory read result is replaced by NOP 32'h0000_0013. The flag rides with the entry, and the entry still consumes a slot and a credit.
- Flush: on an edge with flush=1:
  - all pipeline valid bits, FIFO pointers and count clear;
  - no request is accepted that edge;
  - a pop requested that same edge is discarded.
  - Result: instr_valid=0 and pc_hold=0 after that edge.
- Flush priority: flush has priority over simultaneous push, pop and accept. The first request after the redirect is accepted at the next edge with flush=0.
- Reset (reset=0, asynchronous) clears:
  - pipeline valids, FIFO pointers and count;
  - outputs: instr_valid=0, instr=0, instr_pc=0, misaligned=0, out_of_range=0, pc_hold=0.
- Reset mid-operation discards everything outstanding. Release is synchronous to the next edge.
- Ordering: instructions exit in acceptance order. There is no reordering and no duplication.

Decomposition:
- Shared package/header fetch_pkg:
  - NOP_INSTR = 32'h0000_0013;
  - the pipeline-entry field layout {valid, pc, misaligned, out_of_range} and its width;
  - the LATENCY legality check.
- One sub-module: fetch_fifo, a generic synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/clear, and outputs count/empty/head. It is reused by future load/store buffering.
- The memory array and the pipeline stay in the top module.

Test Plan:
Common setup for all scenarios: memory word i = 32'hA000_0000 + i, LATENCY=2.
1. Streaming: pc_addr 0,4,8,12 on consecutive edges, instr_ready=1 -> instr_valid rises 2 cycles after first accept; instr = A0000000..A0000003 with instr_pc 0..12, one per cycle; pc_hold stays 0.
2. Back-pressure: instr_ready=0 with pc_valid=1 streaming from 0 -> exactly 4 accepts, then pc_hold=1. Head holds A0000000 / pc 0 stable. Raise instr_ready -> drains 4 entries in order, and pc_hold drops the cycle after the first pop.
3. Flush: stream 0,4,8 then flush=1 for one edge with pc_addr=0x40 -> instr_valid=0 next cycle; none of 0,4,8 ever appear. Next accepted 0x40 yields A0000010 two cycles later.
4. Faults: pc_addr=0x6 -> instr=32'h00000013, misaligned=1. pc_addr=0x1000 (MEM_DEPTH=1024) -> NOP, out_of_range=1. Both entries occupy one slot each.
5. Reset mid-operation: 3 entries buffered, reset=0 asynchronously between edges -> instr_valid, pc_hold, instr, instr_pc drop to 0 immediately. After release, stream from 0x20 returns A0000008 first.
6. Simultaneous push/pop with FIFO at FDEPTH-1 and instr_ready=1 -> count unchanged, no overflow, pc_hold never asserts spuriously.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and pipeline-entry layout for the instruction fetch path
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Pipeline entry packing, MSB to LSB: {valid, pc, misaligned, out_of_range}
    localparam int ENTRY_OOR_BIT = 0;
    localparam int ENTRY_MIS_BIT = 1;
    localparam int ENTRY_PC_LSB  = 2;

    function automatic int entry_width(input int addr_w);
        return addr_w + 3;
    endfunction

    function automatic bit latency_legal(input int latency);
        return (latency >= 1) && (latency <= 4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - generic in-order synchronous FIFO with clear, count and registered head
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic [WIDTH-1:0]             head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = store[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= din;
                wr_ptr        <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_responder.sv
// rtl/instr_fetch_responder.sv - fixed-latency instruction memory fetch with credit back-pressure and flush
module instr_fetch_responder
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_valid,
    output logic              pc_hold,
    input  logic              flush,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              misaligned,
    output logic              out_of_range
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int EW     = entry_width(ADDR_W);
    localparam int FDEPTH = LATENCY + 2;
    localparam int FW     = DATA_W + ADDR_W + 2;
    localparam int CW     = $clog2(FDEPTH + 1);
    localparam int IW     = $clog2(LATENCY + 1);

    if (!latency_legal(LATENCY)) begin : g_bad_latency
        $error("instr_fetch_responder: LATENCY must be in 1..4");
    end

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              accept;
    logic              req_mis;
    logic              req_oor;
    logic [EW-1:0]     stg      [LATENCY];
    logic [DATA_W-1:0] stg_data [LATENCY];
    logic [IW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_head;
    logic [EW-1:0]     tail;
    logic              tail_fault;

    assign req_mis = (pc_addr[1:0] != 2'b00);
    assign req_oor = ((pc_addr >> 2) >= ADDR_W'(MEM_DEPTH));
    assign accept  = pc_valid && !pc_hold && !flush;

    // Data path carries no valid, so it needs neither reset nor flush.
    always_ff @(posedge clk) begin
        stg_data[0] <= mem[pc_addr[IDX_W+1:2]];
        for (int i = 1; i < LATENCY; i++) begin
            stg_data[i] <= stg_data[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= {accept, pc_addr, req_mis, req_oor};
            for (int i = 1; i < LATENCY; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + IW'(stg[i][EW-1]);
        end
    end

    // Every outstanding fetch holds a FIFO credit, so a push can never find the FIFO full.
    assign pc_hold = (32'(fifo_count) + 32'(inflight)) >= 32'(FDEPTH);

    assign tail       = stg[LATENCY-1];
    assign tail_fault = tail[ENTRY_MIS_BIT] | tail[ENTRY_OOR_BIT];
    assign fifo_din   = {tail_fault ? DATA_W'(NOP_INSTR) : stg_data[LATENCY-1],
                         tail[ENTRY_PC_LSB +: ADDR_W],
                         tail[ENTRY_MIS_BIT],
                         tail[ENTRY_OOR_BIT]};

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (tail[EW-1]),
        .din   (fifo_din),
        .pop   (instr_valid && instr_ready),
        .count (fifo_count),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign instr_valid = !fifo_empty;
    assign {instr, instr_pc, misaligned, out_of_range} = fifo_head;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// tb/tb_instr_fetch_responder.sv - directed self-checking bench for instr_fetch_responder
module tb_instr_fetch_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        pc_hold;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        misaligned;
    logic        out_of_range;

    int total = 0;
    int bad   = 0;
    int acc;

    instr_fetch_responder #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_DEPTH (1024),
        .LATENCY   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_addr      (pc_addr),
        .pc_valid     (pc_valid),
        .pc_hold      (pc_hold),
        .flush        (flush),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] d, input logic [31:0] pc,
                            input logic mis, input logic oor);
        chk({tag, " valid"}, 64'(instr_valid), 64'd1);
        chk({tag, " instr"}, 64'(instr), 64'(d));
        chk({tag, " pc"}, 64'(instr_pc), 64'(pc));
        chk({tag, " mis"}, 64'(misaligned), 64'(mis));
        chk({tag, " oor"}, 64'(out_of_range), 64'(oor));
    endtask

    initial begin
        reset = 1'b0;
        pc_addr = '0;
        pc_valid = 1'b0;
        flush = 1'b0;
        instr_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            dut.mem[i] = 32'hA000_0000 + 32'(i);
        end
        #1;
        chk("rst valid", 64'(instr_valid), 64'd0);
        chk("rst hold", 64'(pc_hold), 64'd0);
        chk("rst instr", 64'(instr), 64'd0);
        chk("rst pc", 64'(instr_pc), 64'd0);
        chk("rst flags", 64'({misaligned, out_of_range}), 64'd0);
        tick();
        tick();
        reset = 1'b1;

        // 1. streaming with decode always ready
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pc_valid = (k < 4);
            pc_addr  = 32'(4 * k);
            tick();
            chk("s1 hold", 64'(pc_hold), 64'd0);
            if (k < 2) chk("s1 early valid", 64'(instr_valid), 64'd0);
            else chk_head("s1 head", 32'hA000_0000 + 32'(k - 2), 32'(4 * (k - 2)), 1'b0, 1'b0);
        end
        pc_valid = 1'b0;
        tick();
        chk("s1 drained", 64'(instr_valid), 64'd0);

        // 2. back-pressure: PC advances only when not held
        instr_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            pc_valid = 1'b1;
            pc_addr  = 32'(acc * 4);
            if (!pc_hold) acc++;
            tick();
            if (k >= 2) chk_head("s2 stable", 32'hA000_0000, 32'h0, 1'b0, 1'b0);
        end
        chk("s2 accepts", 64'(acc), 64'd4);
        chk("s2 hold", 64'(pc_hold), 64'd1);
        pc_valid = 1'b0;
        instr_ready = 1'b1;
        tick();
        chk("s2 hold drop", 64'(pc_hold), 64'd0);
        chk_head("s2 drain1", 32'hA000_0001, 32'h4, 1'b0, 1'b0);
        tick();
        chk_head("s2 drain2", 32'hA000_0002, 32'h8, 1'b0, 1'b0);
        tick();
        chk_head("s2 drain3", 32'hA000_0003, 32'hC, 1'b0, 1'b0);
        tick();
        chk("s2 empty", 64'(instr_valid), 64'd0);

        // 3. flush kills in-flight and buffered fetches
        pc_valid = 1'b1;
        pc_addr = 32'h0;
        tick();
        pc_addr = 32'h4;
        tick();
        pc_addr = 32'h8;
        tick();
        flush = 1'b1;
        pc_addr = 32'h40;
        tick();
        flush = 1'b0;
        chk("s3 valid after flush", 64'(instr_valid), 64'd0);
        chk("s3 hold after flush", 64'(pc_hold), 64'd0);
        tick();
        chk("s3 valid e4", 64'(instr_valid), 64'd0);
        pc_valid = 1'b0;
        tick();
        chk("s3 valid e5", 64'(instr_valid), 64'd0);
        tick();
        chk_head("s3 redirect", 32'hA000_0010, 32'h40, 1'b0, 1'b0);
        tick();
        chk("s3 empty", 64'(instr_valid), 64'd0);

        // 4. faulting addresses still take a slot and a credit
        instr_ready = 1'b0;
        pc_valid = 1'b1;
        pc_addr = 32'h6;
        tick();
        pc_addr = 32'h1000;
        tick();
        pc_valid = 1'b0;
        tick();
        chk_head("s4 misaligned", 32'h0000_0013, 32'h6, 1'b1, 1'b0);
        pc_valid = 1'b1;
        pc_addr = 32'h0;
        tick();
        chk_head("s4 mis stable", 32'h0000_0013, 32'h6, 1'b1, 1'b0);
        chk("s4 hold at 3", 64'(pc_hold), 64'd0);
        pc_addr = 32'h4;
        tick();
        chk("s4 hold at 4", 64'(pc_hold), 64'd1);
        pc_valid = 1'b0;
        instr_ready = 1'b1;
        tick();
        chk_head("s4 oor", 32'h0000_0013, 32'h1000, 1'b0, 1'b1);
        tick();
        chk_head("s4 next0", 32'hA000_0000, 32'h0, 1'b0, 1'b0);
        tick();
        chk_head("s4 next4", 32'hA000_0001, 32'h4, 1'b0, 1'b0);
        tick();
        chk("s4 empty", 64'(instr_valid), 64'd0);

        // 5. asynchronous reset mid-operation
        instr_ready = 1'b0;
        pc_valid = 1'b1;
        pc_addr = 32'h0;
        tick();
        pc_addr = 32'h4;
        tick();
        pc_addr = 32'h8;
        tick();
        pc_valid = 1'b0;
        tick();
        tick();
        chk("s5 buffered", 64'(dut.fifo_count), 64'd3);
        #3;
        reset = 1'b0;
        #1;
        chk("s5 async valid", 64'(instr_valid), 64'd0);
        chk("s5 async hold", 64'(pc_hold), 64'd0);
        chk("s5 async instr", 64'(instr), 64'd0);
        chk("s5 async pc", 64'(instr_pc), 64'd0);
        tick();
        reset = 1'b1;
        instr_ready = 1'b1;
        pc_valid = 1'b1;
        pc_addr = 32'h20;
        tick();
        pc_valid = 1'b0;
        tick();
        chk("s5 not yet", 64'(instr_valid), 64'd0);
        tick();
        chk_head("s5 first", 32'hA000_0008, 32'h20, 1'b0, 1'b0);
        tick();
        chk("s5 empty", 64'(instr_valid), 64'd0);

        // 6. push and pop on the same edge with FIFO at FDEPTH-1
        instr_ready = 1'b0;
        pc_valid = 1'b1;
        pc_addr = 32'h0;
        tick();
        pc_addr = 32'h4;
        tick();
        pc_addr = 32'h8;
        tick();
        pc_valid = 1'b0;
        tick();
        tick();
        chk("s6 count3", 64'(dut.fifo_count), 64'd3);
        chk("s6 hold at 3", 64'(pc_hold), 64'd0);
        pc_valid = 1'b1;
        pc_addr = 32'hC;
        tick();
        pc_valid = 1'b0;
        chk("s6 hold full credit", 64'(pc_hold), 64'd1);
        tick();
        instr_ready = 1'b1;
        tick();
        chk("s6 count same", 64'(dut.fifo_count), 64'd3);
        chk("s6 hold after pp", 64'(pc_hold), 64'd0);
        chk_head("s6 head4", 32'hA000_0001, 32'h4, 1'b0, 1'b0);
        tick();
        chk("s6 hold drain", 64'(pc_hold), 64'd0);
        chk_head("s6 head8", 32'hA000_0002, 32'h8, 1'b0, 1'b0);
        tick();
        chk_head("s6 head12", 32'hA000_0003, 32'hC, 1'b0, 1'b0);
        tick();
        chk("s6 empty", 64'(instr_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
